// File: rtl/morph_pkg.sv
// Shared definitions for the morphology bounding-box detector.
package morph_pkg;

    // Frame-tracking FSM encoding; also visible on the debug state output.
    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACTIVE     = 2'd1,
        LATCH      = 2'd2
    } state_e;

    localparam int CNT_WIDTH_DEF     = 12;
    localparam int CNT_PIX_WIDTH_DEF = 20;

    // True when every coordinate 0..dim-1 fits in a width-bit counter.
    function automatic bit dims_fit(input int dim, input int width);
        return dim <= (1 << width);
    endfunction

endpackage

// File: rtl/morph_edge_det.sv
// Registered rise/fall detector: flags appear one cycle after the transition.
module morph_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic prev_q, prev_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Compare the current sample with the previous one.
    always_comb begin
        prev_d = sig_in;
        rise_d = sig_in & ~prev_q;
        fall_d = ~sig_in & prev_q;
    end

    // History and flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/morph_bbox_detect.sv
// Bounding box and foreground count of a binary frame from the erosion stage.
// Pixels are registered once so they line up with the registered hs/vs edge
// flags; the datapath then acts on that aligned sample, giving a 2-cycle path
// from input pin to working state.
module morph_bbox_detect
    import morph_pkg::*;
#(
    parameter int IMG_WIDTH     = 640,
    parameter int IMG_HEIGHT    = 480,
    parameter int CNT_WIDTH     = CNT_WIDTH_DEF,
    parameter int CNT_PIX_WIDTH = CNT_PIX_WIDTH_DEF,
    parameter int MIN_PIXELS    = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     data_in,
    input  logic                     data_in_valid,
    input  logic                     data_in_hs,
    input  logic                     data_in_vs,
    output logic [CNT_WIDTH-1:0]     box_x_min,
    output logic [CNT_WIDTH-1:0]     box_x_max,
    output logic [CNT_WIDTH-1:0]     box_y_min,
    output logic [CNT_WIDTH-1:0]     box_y_max,
    output logic [CNT_PIX_WIDTH-1:0] pix_count,
    output logic                     box_valid,
    output logic                     frame_done,
    output logic [1:0]               state_dbg
);

    // Refuse to elaborate when the coordinate counters cannot reach the edges.
    if (!dims_fit(IMG_WIDTH, CNT_WIDTH) || !dims_fit(IMG_HEIGHT, CNT_WIDTH)) begin : g_cnt_width_too_small
        $error("CNT_WIDTH too narrow for IMG_WIDTH/IMG_HEIGHT");
    end

    localparam logic [CNT_WIDTH-1:0]     C_ONE   = 1;
    localparam logic [CNT_PIX_WIDTH-1:0] P_ONE   = 1;
    localparam logic [CNT_PIX_WIDTH-1:0] MIN_PIX = CNT_PIX_WIDTH'(MIN_PIXELS);

    // ---------------- edge detection ----------------
    logic hs_rise, hs_fall, vs_rise, vs_fall;

    morph_edge_det u_hs_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_in  (data_in_hs),
        .rise    (hs_rise),
        .fall    (hs_fall)
    );

    morph_edge_det u_vs_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_in  (data_in_vs),
        .rise    (vs_rise),
        .fall    (vs_fall)
    );

    // ---------------- registers ----------------
    state_e state_q, state_d;

    logic pix_q,   pix_d;
    logic pval_q,  pval_d;
    logic phs_q,   phs_d;
    logic pvs_q,   pvs_d;
    // Set once vs has been seen low since reset, so a reset released in the
    // middle of a frame cannot turn the still-high vs into a frame start.
    logic vs_armed_q, vs_armed_d;

    logic [CNT_WIDTH-1:0]     x_cnt_q, x_cnt_d;
    logic [CNT_WIDTH-1:0]     y_cnt_q, y_cnt_d;
    logic                     line_pix_q, line_pix_d;
    logic [CNT_PIX_WIDTH-1:0] work_cnt_q, work_cnt_d;
    logic                     any_fg_q, any_fg_d;
    logic [CNT_WIDTH-1:0]     work_xmin_q, work_xmin_d;
    logic [CNT_WIDTH-1:0]     work_xmax_q, work_xmax_d;
    logic [CNT_WIDTH-1:0]     work_ymin_q, work_ymin_d;
    logic [CNT_WIDTH-1:0]     work_ymax_q, work_ymax_d;

    logic [CNT_WIDTH-1:0]     box_x_min_q, box_x_min_d;
    logic [CNT_WIDTH-1:0]     box_x_max_q, box_x_max_d;
    logic [CNT_WIDTH-1:0]     box_y_min_q, box_y_min_d;
    logic [CNT_WIDTH-1:0]     box_y_max_q, box_y_max_d;
    logic [CNT_PIX_WIDTH-1:0] pix_count_q, pix_count_d;
    logic                     box_valid_q, box_valid_d;
    logic                     frame_done_q, frame_done_d;

    logic frame_start;
    logic clear_work;
    logic latch_out;

    // FSM next state: frames start only on a genuine vs rise, LATCH lasts one cycle.
    always_comb begin
        state_d     = state_q;
        clear_work  = 1'b0;
        latch_out   = 1'b0;
        frame_start = vs_rise & vs_armed_q;
        case (state_q)
            WAIT_FRAME: begin
                if (frame_start) begin
                    state_d    = ACTIVE;
                    clear_work = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_fall) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                latch_out = 1'b1;
                if (frame_start) begin
                    state_d    = ACTIVE;
                    clear_work = 1'b1;
                end else begin
                    state_d = WAIT_FRAME;
                end
            end
            default: state_d = WAIT_FRAME;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_FRAME;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: input alignment, line/column counters, box accumulation and result latch.
    logic [CNT_WIDTH-1:0] x_cur;
    logic                 line_cur;
    logic                 pix_ok;

    always_comb begin
        pix_d        = data_in;
        pval_d       = data_in_valid;
        phs_d        = data_in_hs;
        pvs_d        = data_in_vs;
        vs_armed_d   = vs_armed_q | ~data_in_vs;

        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        line_pix_d   = line_pix_q;
        work_cnt_d   = work_cnt_q;
        any_fg_d     = any_fg_q;
        work_xmin_d  = work_xmin_q;
        work_xmax_d  = work_xmax_q;
        work_ymin_d  = work_ymin_q;
        work_ymax_d  = work_ymax_q;

        box_x_min_d  = box_x_min_q;
        box_x_max_d  = box_x_max_q;
        box_y_min_d  = box_y_min_q;
        box_y_max_d  = box_y_max_q;
        pix_count_d  = pix_count_q;
        box_valid_d  = box_valid_q;
        frame_done_d = 1'b0;

        // A line start restarts the column count for the pixel sampled with it.
        x_cur    = hs_rise ? '0 : x_cnt_q;
        line_cur = hs_rise ? 1'b0 : line_pix_q;
        pix_ok   = (state_q == ACTIVE) & pval_q & phs_q & pvs_q;

        if (clear_work) begin
            x_cnt_d     = '0;
            y_cnt_d     = '0;
            line_pix_d  = 1'b0;
            work_cnt_d  = '0;
            any_fg_d    = 1'b0;
            work_xmin_d = '1;
            work_ymin_d = '1;
            work_xmax_d = '0;
            work_ymax_d = '0;
        end else if (state_q == ACTIVE) begin
            x_cnt_d    = x_cur;
            line_pix_d = line_cur;
            if (pix_ok) begin
                line_pix_d = 1'b1;
                if (x_cur != '1) begin
                    x_cnt_d = x_cur + C_ONE;
                end
                if (pix_q) begin
                    any_fg_d = 1'b1;
                    if (work_cnt_q != '1) begin
                        work_cnt_d = work_cnt_q + P_ONE;
                    end
                    if (x_cur < work_xmin_q)   work_xmin_d = x_cur;
                    if (x_cur > work_xmax_q)   work_xmax_d = x_cur;
                    if (y_cnt_q < work_ymin_q) work_ymin_d = y_cnt_q;
                    if (y_cnt_q > work_ymax_q) work_ymax_d = y_cnt_q;
                end
            end
            // Lines that carried no valid pixel do not advance the row.
            if (hs_fall && line_pix_q) begin
                line_pix_d = 1'b0;
                if (y_cnt_q != '1) begin
                    y_cnt_d = y_cnt_q + C_ONE;
                end
            end
        end

        if (latch_out) begin
            if (any_fg_q) begin
                box_x_min_d = work_xmin_q;
                box_x_max_d = work_xmax_q;
                box_y_min_d = work_ymin_q;
                box_y_max_d = work_ymax_q;
            end else begin
                box_x_min_d = '0;
                box_x_max_d = '0;
                box_y_min_d = '0;
                box_y_max_d = '0;
            end
            pix_count_d  = work_cnt_q;
            box_valid_d  = (work_cnt_q >= MIN_PIX);
            frame_done_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_q        <= 1'b0;
            pval_q       <= 1'b0;
            phs_q        <= 1'b0;
            pvs_q        <= 1'b0;
            vs_armed_q   <= 1'b0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            line_pix_q   <= 1'b0;
            work_cnt_q   <= '0;
            any_fg_q     <= 1'b0;
            work_xmin_q  <= '0;
            work_xmax_q  <= '0;
            work_ymin_q  <= '0;
            work_ymax_q  <= '0;
            box_x_min_q  <= '0;
            box_x_max_q  <= '0;
            box_y_min_q  <= '0;
            box_y_max_q  <= '0;
            pix_count_q  <= '0;
            box_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            pix_q        <= pix_d;
            pval_q       <= pval_d;
            phs_q        <= phs_d;
            pvs_q        <= pvs_d;
            vs_armed_q   <= vs_armed_d;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            line_pix_q   <= line_pix_d;
            work_cnt_q   <= work_cnt_d;
            any_fg_q     <= any_fg_d;
            work_xmin_q  <= work_xmin_d;
            work_xmax_q  <= work_xmax_d;
            work_ymin_q  <= work_ymin_d;
            work_ymax_q  <= work_ymax_d;
            box_x_min_q  <= box_x_min_d;
            box_x_max_q  <= box_x_max_d;
            box_y_min_q  <= box_y_min_d;
            box_y_max_q  <= box_y_max_d;
            pix_count_q  <= pix_count_d;
            box_valid_q  <= box_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign box_x_min  = box_x_min_q;
    assign box_x_max  = box_x_max_q;
    assign box_y_min  = box_y_min_q;
    assign box_y_max  = box_y_max_q;
    assign pix_count  = pix_count_q;
    assign box_valid  = box_valid_q;
    assign frame_done = frame_done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_morph_bbox_detect.sv
// Directed bench for morph_bbox_detect on an 8x4 frame with MIN_PIXELS=16.
// Stream handshake: a pixel is taken when data_in_valid, data_in_hs and
// data_in_vs are all high; anything else on the pixel lines is ignored.
module tb_morph_bbox_detect;

    localparam int CW = 12;
    localparam int PW = 20;
    localparam int RW = 4 * CW + PW + 1;

    typedef struct packed {
        logic [CW-1:0] xmin;
        logic [CW-1:0] xmax;
        logic [CW-1:0] ymin;
        logic [CW-1:0] ymax;
        logic [PW-1:0] cnt;
        logic          valid;
    } res_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          data_in;
    logic          data_in_valid;
    logic          data_in_hs;
    logic          data_in_vs;
    logic [CW-1:0] box_x_min;
    logic [CW-1:0] box_x_max;
    logic [CW-1:0] box_y_min;
    logic [CW-1:0] box_y_max;
    logic [PW-1:0] pix_count;
    logic          box_valid;
    logic          frame_done;
    logic [1:0]    state_dbg;

    int checks   = 0;
    int failures = 0;

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] got_q[$];

    morph_bbox_detect #(
        .IMG_WIDTH     (8),
        .IMG_HEIGHT    (4),
        .CNT_WIDTH     (CW),
        .CNT_PIX_WIDTH (PW),
        .MIN_PIXELS    (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_hs    (data_in_hs),
        .data_in_vs    (data_in_vs),
        .box_x_min     (box_x_min),
        .box_x_max     (box_x_max),
        .box_y_min     (box_y_min),
        .box_y_max     (box_y_max),
        .pix_count     (pix_count),
        .box_valid     (box_valid),
        .frame_done    (frame_done),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Capture every result at its frame_done pulse, away from the active edge.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && frame_done === 1'b1) begin
            got_q.push_back({box_x_min, box_x_max, box_y_min, box_y_max, pix_count, box_valid});
        end
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk_res(input int xmin, input int xmax, input int ymin,
                                             input int ymax, input int cnt, input logic v);
        res_t r;
        r.xmin  = CW'(xmin);
        r.xmax  = CW'(xmax);
        r.ymin  = CW'(ymin);
        r.ymax  = CW'(ymax);
        r.cnt   = PW'(cnt);
        r.valid = v;
        return r;
    endfunction

    // Pop the next expected and captured result and compare field by field.
    task automatic check_next(input string tag, input bit check_live);
        res_t e;
        res_t g;
        e = res_t'(exp_q.pop_front());
        g = '0;
        if (got_q.size() > 0) g = res_t'(got_q.pop_front());
        check_eq({tag, "_xmin"},  32'(g.xmin),  32'(e.xmin));
        check_eq({tag, "_xmax"},  32'(g.xmax),  32'(e.xmax));
        check_eq({tag, "_ymin"},  32'(g.ymin),  32'(e.ymin));
        check_eq({tag, "_ymax"},  32'(g.ymax),  32'(e.ymax));
        check_eq({tag, "_count"}, 32'(g.cnt),   32'(e.cnt));
        check_eq({tag, "_valid"}, 32'(g.valid), 32'(e.valid));
        if (check_live) begin
            check_eq({tag, "_hold_xmax"},  32'(box_x_max), 32'(e.xmax));
            check_eq({tag, "_hold_count"}, 32'(pix_count), 32'(e.cnt));
        end
    endtask

    // Bounded wait for n results, then confirm no extra pulse follows.
    task automatic wait_done(input int n, input string tag);
        for (int k = 0; k < 60 && got_q.size() < n; k++) begin
            @(posedge clk); #1;
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        check_eq({tag, "_frame_done_count"}, 32'(got_q.size()), 32'(n));
    endtask

    // ---------------- drivers ----------------
    task automatic cyc(input logic vs, input logic hs, input logic v, input logic d);
        data_in_vs    = vs;
        data_in_hs    = hs;
        data_in_valid = v;
        data_in       = d;
        @(posedge clk); #1;
    endtask

    // Blank cycles inside a frame carry junk valid foreground with hs low.
    task automatic gap(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic drive_line(input logic [7:0] row);
        for (int x = 0; x < 8; x++) cyc(1'b1, 1'b1, 1'b1, row[x]);
    endtask

    // img bit y*8+x is pixel (x, y); vs drops right after the last pixel.
    task automatic drive_frame(input logic [31:0] img, input int post, input bit blank_line);
        gap(2);
        if (blank_line) begin
            repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b1);
            gap(2);
        end
        for (int y = 0; y < 4; y++) begin
            drive_line(img[y*8 +: 8]);
            if (y < 3) gap(2);
        end
        repeat (post) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_n       = 1'b0;
        data_in       = 1'b0;
        data_in_valid = 1'b0;
        data_in_hs    = 1'b0;
        data_in_vs    = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        check_eq("rst_xmin",  32'(box_x_min), 32'd0);
        check_eq("rst_xmax",  32'(box_x_max), 32'd0);
        check_eq("rst_ymin",  32'(box_y_min), 32'd0);
        check_eq("rst_ymax",  32'(box_y_max), 32'd0);
        check_eq("rst_count", 32'(pix_count), 32'd0);
        check_eq("rst_valid", 32'(box_valid), 32'd0);
        check_eq("rst_done",  32'(frame_done), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'd0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Single pixel at (3,2), preceded by a line without valid pixels.
        exp_q.push_back(mk_res(3, 3, 2, 2, 1, 1'b0));
        drive_frame(32'h0008_0000, 3, 1'b1);
        wait_done(1, "single");
        check_next("single", 1'b1);

        // 4x4 block at x=2..5, y=0..3: exactly MIN_PIXELS.
        exp_q.push_back(mk_res(2, 5, 0, 3, 16, 1'b1));
        drive_frame(32'h3C3C_3C3C, 3, 1'b0);
        wait_done(1, "block16");
        check_next("block16", 1'b1);

        // All-zero frame.
        exp_q.push_back(mk_res(0, 0, 0, 0, 0, 1'b0));
        drive_frame(32'h0000_0000, 3, 1'b0);
        wait_done(1, "empty");
        check_next("empty", 1'b1);

        // Only the very last pixel (7,3), immediately followed by the vs fall.
        exp_q.push_back(mk_res(7, 7, 3, 3, 1, 1'b0));
        drive_frame(32'h8000_0000, 3, 1'b0);
        wait_done(1, "last_pix");
        check_next("last_pix", 1'b1);

        // One short of MIN_PIXELS.
        exp_q.push_back(mk_res(2, 5, 0, 3, 15, 1'b0));
        drive_frame(32'h3C3C_3C1C, 3, 1'b0);
        wait_done(1, "block15");
        check_next("block15", 1'b1);

        // Reset in the middle of a frame; the rest of that frame must be ignored.
        gap(2);
        drive_line(8'hFF);
        gap(2);
        drive_line(8'hFF);
        reset_n = 1'b0;
        repeat (2) cyc(1'b1, 1'b0, 1'b1, 1'b1);
        reset_n = 1'b1;
        check_eq("midrst_xmax",  32'(box_x_max), 32'd0);
        check_eq("midrst_count", 32'(pix_count), 32'd0);
        gap(2);
        drive_line(8'hFF);
        check_eq("midrst_state_idle", 32'(state_dbg), 32'd0);
        gap(2);
        drive_line(8'hFF);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1);
        wait_done(0, "partial");
        exp_q.push_back(mk_res(1, 2, 1, 2, 4, 1'b0));
        drive_frame(32'h0006_0600, 3, 1'b0);
        wait_done(1, "after_rst");
        check_next("after_rst", 1'b1);

        // Back-to-back frames: the second vs rise lands in the LATCH cycle.
        exp_q.push_back(mk_res(2, 5, 0, 3, 16, 1'b1));
        exp_q.push_back(mk_res(6, 6, 1, 1, 1, 1'b0));
        drive_frame(32'h3C3C_3C3C, 1, 1'b0);
        drive_frame(32'h0000_4000, 3, 1'b0);
        wait_done(2, "b2b");
        check_next("b2b_first", 1'b0);
        check_next("b2b_second", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/morph_bbox_detect.md
MORPH_BBOX_DETECT -- requirements
Module: morph_bbox_detect

Interface
REQ-001 Parameter IMG_WIDTH, default 640: active pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 480: active lines per frame.
REQ-003 Parameter CNT_WIDTH, default 12: width of the x/y coordinates; shall hold IMG_WIDTH-1 and IMG_HEIGHT-1.
REQ-004 Parameter CNT_PIX_WIDTH, default 20: width of the foreground pixel counter.
REQ-005 Parameter MIN_PIXELS, default 16: minimum foreground count for a valid box.
REQ-006 clk  input  1  pixel clock; the only clock.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 data_in  input  1  binary pixel from the upstream erosion stage; 1 = foreground.
REQ-009 data_in_valid  input  1  data_in is a valid pixel.
REQ-010 data_in_hs  input  1  line active, high for the whole line.
REQ-011 data_in_vs  input  1  frame active, high for the whole frame.
REQ-012 box_x_min / box_x_max  output  CNT_WIDTH  leftmost and rightmost foreground column.
REQ-013 box_y_min / box_y_max  output  CNT_WIDTH  top and bottom foreground row.
REQ-014 pix_count  output  CNT_PIX_WIDTH  foreground pixels in the last frame.
REQ-015 box_valid  output  1  pix_count >= MIN_PIXELS for the last frame.
REQ-016 frame_done  output  1  one-cycle pulse when all result outputs are updated.

Function
REQ-017 Registered edge detectors shall flag the vs rise, vs fall, hs rise and hs fall one cycle after each transition.
REQ-018 FSM states:
- WAIT_FRAME: leave on vs rise, go to ACTIVE.
- ACTIVE: leave on vs fall, go to LATCH.
- LATCH: go to WAIT_FRAME after one cycle.
REQ-019 In WAIT_FRAME, no pixel shall update the accumulators.
REQ-020 On entry to ACTIVE, working state shall clear:
- x_cnt = 0, y_cnt = 0, work_cnt = 0, any_fg = 0
- work_xmin = work_ymin = all-ones
- work_xmax = work_ymax = 0
REQ-021 x_cnt:
- increments once per valid pixel in ACTIVE;
- clears on hs rise;
- saturates at all-ones.
REQ-022 y_cnt shall increment on hs fall in ACTIVE only if the line had at least one valid pixel, and shall saturate at all-ones.
REQ-023 A valid pixel with data_in=1 in ACTIVE shall:
- update the work min/max with the current (x_cnt, y_cnt) in the same cycle;
- increment work_cnt, saturating at all-ones.
REQ-024 Processing latency: a valid pixel shall appear in the working state 2 cycles after it is sampled.
- All pixel, hs and vs samples pass through the same 2-cycle delay.
- A pixel in the same cycle as the vs fall is therefore counted.
REQ-025 In LATCH, the working state shall be copied to the outputs, and frame_done shall pulse one cycle later, with the outputs already stable.
REQ-026 Empty frame (work_cnt = 0): all four box outputs = 0, pix_count = 0, box_valid = 0, frame_done still pulses.
REQ-027 box_valid = (work_cnt >= MIN_PIXELS), computed at LATCH.
REQ-028 Result outputs shall hold their value between frame_done pulses.
REQ-029 A vs rise while in LATCH shall be honoured: the FSM enters ACTIVE on the next cycle with cleared working state, and no frame shall be lost.
REQ-030 data_in_valid while hs=0 or vs=0 shall be ignored.

Reset
REQ-031 reset_n=0 shall asynchronously force:
- FSM to WAIT_FRAME;
- all counters, working registers and outputs to 0;
- edge-detect history to 0.
REQ-032 After reset is released mid-frame, no results shall be produced until a full vs rise/fall cycle has been seen; the first frame_done follows the first complete frame.

Structure
REQ-033 Shared package morph_pkg shall hold:
- the FSM state encoding (WAIT_FRAME, ACTIVE, LATCH);
- the CNT_WIDTH default.
REQ-034 The rise/fall detector shall be one sub-module, morph_edge_det (1-bit input; rise and fall outputs), instantiated for hs and for vs.
REQ-035 Everything else shall be a single always-block datapath plus the FSM in morph_bbox_detect; no memories.

Verification
REQ-036 8x4 frame, single foreground pixel at (x=3, y=2) -> x_min = x_max = 3, y_min = y_max = 2, pix_count = 1, box_valid = 0 (MIN_PIXELS=16), one frame_done pulse.
REQ-037 8x4 frame, 4x4 block of ones at x=2..5, y=0..3 -> box (2, 5, 0, 3), pix_count = 16, box_valid = 1.
REQ-038 All-zero frame -> all box outputs 0, pix_count = 0, box_valid = 0, frame_done pulses.
REQ-039 Last pixel of the frame =1 at (7, 3), in the same cycle as the vs fall -> x_max = 7, y_max = 3, and the pixel is counted.
REQ-040 Assert reset_n=0 mid-frame, release, then feed a full frame with a box at (1, 1)-(2, 2) -> no frame_done for the partial frame; the next frame reports (1, 2, 1, 2), pix_count = 4.
REQ-041 Back-to-back frames with a vs rise in the LATCH cycle -> two frame_done pulses, and the second result is independent of the first.
